// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   - IFU_RESET_PC  : default PC loaded at reset
//   - FIFO_DEPTH    : instruction queue depth (fixed at 2)
//   - OPC_MSB/LSB   : opcode field range inside an instruction word
//   - ifu_state_e   : fetch FSM states (IDLE, FETCH, HALT)
//   - fetch_entry_t : one queued {pc, instr} pair
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam int          FIFO_DEPTH   = 2;
  localparam int          OPC_MSB      = 6;
  localparam int          OPC_LSB      = 0;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_HALT  = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: 2-entry {pc, instr} queue between the ITCM response path and decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the queue; overrides push and pop in the same cycle
//   push       : write push_data at the tail (caller guarantees space, or a pop)
//   pop        : retire the head entry
//   head       : registered head entry (stable while not popped)
//   count      : number of valid entries, 0..2
module ifu_fifo
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [FIFO_DEPTH];
  fetch_entry_t mem_d [FIFO_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q,  count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      // On a full queue with push and pop together, the tail slot is the
      // head slot being vacated, so the write and the pop use the same entry.
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset here because the head entry drives if_pc/if_instr, which must read 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Owns the PC, fetches words from the ITCM over a
// req/gnt port (rvalid exactly one cycle after grant), queues responses in
// ifu_fifo and presents {pc, instr, opcode} to decode over valid/ready.
// Redirects from execute reload the PC, flush the queue and kill in-flight
// responses.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   redirect_valid/redirect_pc : taken branch / jump target
//   itcm_req/itcm_addr/itcm_gnt: fetch request port
//   itcm_rvalid/itcm_rdata     : fetch response port
//   if_valid/if_ready          : decode handshake
//   if_instr/if_pc/if_opcode   : instruction presented to decode
//   if_misalign                : misaligned redirect seen (HALT)
// Build option: define IFU_MISALIGN_CHK_EN to halt on redirects with
// redirect_pc[1:0] != 0; otherwise those bits are ignored and if_misalign is 0.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        itcm_req,
  output logic [31:0] itcm_addr,
  input  logic        itcm_gnt,
  input  logic        itcm_rvalid,
  input  logic [31:0] itcm_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode,
  output logic        if_misalign
);

  ifu_state_e   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic [1:0]   inflight_q, inflight_d;
  logic [1:0]   kill_q, kill_d;

  logic         fire;
  logic         pop;
  logic         rsp_take;
  logic         push;
  logic         misaligned;
  logic [2:0]   credits;
  logic [31:0]  target_pc;
  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_push_data;

  // Targets are always word aligned; the low bits only feed the misalign check.
  assign target_pc = {redirect_pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHK_EN
  assign misaligned  = |redirect_pc[1:0];
  assign if_misalign = (state_q == IFU_HALT);
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign misaligned  = 1'b0;
  assign if_misalign = 1'b0;
`endif

  assign pop      = if_valid & if_ready;
  // Only responses we are still owed count; a stray rvalid is ignored.
  assign rsp_take = itcm_rvalid & (inflight_q != 2'd0);
  // Slots already claimed: queued + in flight, minus the entry leaving now.
  assign credits  = {1'b0, q_count} + {1'b0, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    kill_d     = kill_q;
    itcm_req   = (state_q == IFU_FETCH) && !redirect_valid && (credits < 3'd2);
    fire       = itcm_req & itcm_gnt;
    push       = rsp_take && (kill_q == 2'd0) && !redirect_valid;
    inflight_d = inflight_q + {1'b0, fire} - {1'b0, rsp_take};

    if (fire) begin
      rsp_pc_d = pc_q;
    end

    case (state_q)
      IFU_IDLE:  state_d = IFU_FETCH;
      IFU_FETCH: state_d = IFU_FETCH;
      IFU_HALT:  state_d = IFU_HALT;
      default:   state_d = IFU_IDLE;
    endcase

    if (redirect_valid) begin
      // Everything still owed after this cycle belongs to the old path.
      pc_d    = target_pc;
      kill_d  = inflight_d;
      state_d = misaligned ? IFU_HALT : IFU_FETCH;
    end else begin
      if (fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_take && (kill_q != 2'd0)) begin
        kill_d = kill_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IFU_IDLE;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= 2'd0;
      kill_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  assign q_push_data = '{pc: rsp_pc_q, instr: itcm_rdata};

  ifu_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (q_push_data),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign itcm_addr = pc_q;
  assign if_valid  = (q_count != 2'd0);
  assign if_instr  = q_head.instr;
  assign if_pc     = q_head.pc;
  assign if_opcode = q_head.instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for ifu. The ITCM model answers every grant one
// cycle later with a word derived from the address; the reference model is the
// architectural instruction stream (next expected PC, advanced by 4 on every
// decode accept and reloaded on every redirect).
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        itcm_req;
  logic [31:0] itcm_addr;
  logic        itcm_gnt = 1'b0;
  logic        itcm_rvalid = 1'b0;
  logic [31:0] itcm_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic        if_misalign;

  ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .itcm_req       (itcm_req),
    .itcm_addr      (itcm_addr),
    .itcm_gnt       (itcm_gnt),
    .itcm_rvalid    (itcm_rvalid),
    .itcm_rdata     (itcm_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode),
    .if_misalign    (if_misalign)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  logic [31:0] ew;

  // Per-cycle observations, sampled on the falling edge.
  logic        o_valid, o_req, o_mis, o_fire;
  logic [31:0] o_pc, o_instr, o_addr;
  logic [6:0]  o_opc;

  function automatic logic [31:0] itcm_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs (called just after a rising edge), sample at
  // the falling edge, then model the ITCM response for the following cycle.
  task automatic step(input logic rdy, input logic gnt, input logic redir,
                      input logic [31:0] rpc);
    if_ready       = rdy;
    itcm_gnt       = gnt;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
    o_valid = if_valid;
    o_pc    = if_pc;
    o_instr = if_instr;
    o_opc   = if_opcode;
    o_req   = itcm_req;
    o_addr  = itcm_addr;
    o_mis   = if_misalign;
    o_fire  = itcm_req & itcm_gnt;
    @(posedge clk);
    #1;
    itcm_rvalid = o_fire;
    itcm_rdata  = o_fire ? itcm_word(o_addr) : $urandom;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({if_valid, itcm_req, if_misalign} !== 3'b000 || itcm_addr !== 32'h0 ||
        if_pc !== 32'h0 || if_instr !== 32'h0 || if_opcode !== 7'h0) begin
      bad++;
      $display("FAIL reset_values: valid=%b req=%b mis=%b addr=%h pc=%h instr=%h opc=%h, want all 0",
               if_valid, itcm_req, if_misalign, itcm_addr, if_pc, if_instr, if_opcode);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic test_first_fetch;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        total++;
        if (o_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: req=%b want 0", o_req); end
      end
      if (i == 1) begin
        total++;
        if (o_req !== 1'b1 || o_addr !== 32'h0) begin
          bad++; $display("FAIL first_req: req=%b addr=%h want 1/00000000", o_req, o_addr);
        end
      end
      if (i == 2) begin
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL early_valid: valid=%b want 0 at cycle 2", o_valid); end
      end
      if (i >= 3) begin
        total++;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL throughput: valid=%b want 1 at cycle %0d", o_valid, i); end
      end
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew || o_opc !== ew[6:0]) begin
          bad++; $display("FAIL first_stream: pc=%h instr=%h opc=%h want pc=%h instr=%h", o_pc, o_instr, o_opc, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_stall;
    int          grants;
    logic        held;
    logic [31:0] hold_pc, hold_instr;
    grants = 0;
    held   = 1'b0;
    hold_pc = '0;
    hold_instr = '0;
    // Drain so the stall starts from an empty pipe.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew) begin
          bad++; $display("FAIL stall_drain: pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instr, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (o_fire) grants++;
      if (o_valid && !held) begin
        held = 1'b1; hold_pc = o_pc; hold_instr = o_instr;
      end else if (held) begin
        total++;
        if (o_valid !== 1'b1 || o_pc !== hold_pc || o_instr !== hold_instr) begin
          bad++; $display("FAIL stall_hold: valid=%b pc=%h instr=%h want 1/%h/%h", o_valid, o_pc, o_instr, hold_pc, hold_instr);
        end
      end
    end
    total++;
    if (grants != 2) begin bad++; $display("FAIL stall_grants: got %0d grants want 2", grants); end
    total++;
    if (hold_pc !== exp_pc) begin bad++; $display("FAIL stall_head: head pc=%h want %h", hold_pc, exp_pc); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew || o_opc !== ew[6:0]) begin
          bad++; $display("FAIL stall_release: pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instr, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_redirect;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew) begin
          bad++; $display("FAIL redir_drain: pc=%h want %h", o_pc, exp_pc);
        end
        exp_pc += 32'd4;
      end
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    total++;
    if (o_fire !== 1'b1) begin bad++; $display("FAIL redir_setup: fire=%b want 1", o_fire); end
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    exp_pc = 32'h0000_0100;
    total++;
    if (o_req !== 1'b0) begin bad++; $display("FAIL redir_req_suppress: req=%b want 0", o_req); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        total++;
        if (o_req !== 1'b1 || o_addr !== 32'h0000_0100) begin
          bad++; $display("FAIL redir_first_req: req=%b addr=%h want 1/00000100", o_req, o_addr);
        end
      end
      if (i < 2) begin
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble: valid=%b pc=%h want 0 at R+%0d", o_valid, o_pc, i + 1); end
      end
      if (i == 2) begin
        total++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0000_0100) begin
          bad++; $display("FAIL redir_target: valid=%b pc=%h want 1/00000100 at R+3", o_valid, o_pc);
        end
      end
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew || o_opc !== ew[6:0]) begin
          bad++; $display("FAIL redir_stream: pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instr, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_gnt_toggle;
    int gaps, accepts;
    gaps = 0;
    accepts = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, (i % 2) == 0, 1'b0, 32'h0);
      if (!o_valid) gaps++;
      if (o_valid) begin
        accepts++;
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew) begin
          bad++; $display("FAIL toggle_stream: pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instr, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
    end
    total++;
    if (gaps == 0 || accepts < 5) begin
      bad++; $display("FAIL toggle_shape: gaps=%0d accepts=%0d want gaps>0 accepts>=5", gaps, accepts);
    end
  endtask

  task automatic test_wrap;
    int accepts;
    logic seen_zero;
    accepts = 0;
    seen_zero = 1'b0;
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (o_valid) begin
        accepts++;
        if (o_pc === 32'h0) seen_zero = 1'b1;
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew) begin
          bad++; $display("FAIL wrap_stream: pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instr, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
    end
    total++;
    if (!seen_zero || accepts < 5) begin
      bad++; $display("FAIL wrap_zero: seen_zero=%b accepts=%0d want 1 and >=5", seen_zero, accepts);
    end
  endtask

  task automatic test_misalign;
    step(1'b0, 1'b1, 1'b1, 32'h0000_0102);
`ifdef IFU_MISALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      total++;
      if (o_mis !== 1'b1 || o_req !== 1'b0 || o_valid !== 1'b0) begin
        bad++; $display("FAIL halt_state: mis=%b req=%b valid=%b want 1/0/0", o_mis, o_req, o_valid);
      end
    end
`else
    exp_pc = 32'h0000_0100;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      total++;
      if (o_mis !== 1'b0) begin bad++; $display("FAIL misalign_tied: mis=%b want 0", o_mis); end
      if (i == 2) begin
        total++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0000_0100) begin
          bad++; $display("FAIL misalign_forced: valid=%b pc=%h want 1/00000100", o_valid, o_pc);
        end
      end
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew) begin
          bad++; $display("FAIL misalign_stream: pc=%h want %h", o_pc, exp_pc);
        end
        exp_pc += 32'd4;
      end
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
`endif
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    exp_pc = 32'h0000_0200;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 2) begin
        total++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0000_0200 || o_mis !== 1'b0) begin
          bad++; $display("FAIL realign_target: valid=%b pc=%h mis=%b want 1/00000200/0", o_valid, o_pc, o_mis);
        end
      end
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew) begin
          bad++; $display("FAIL realign_stream: pc=%h want %h", o_pc, exp_pc);
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_random;
    int   accepts;
    logic rdy, gnt, redir;
    logic [31:0] tgt;
    accepts = 0;
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(0, 99) < 3);
      rdy   = !redir && ($urandom_range(0, 99) < 70);
      gnt   = ($urandom_range(0, 99) < 70);
      tgt   = $urandom & 32'hFFFF_FFFC;
      step(rdy, gnt, redir, tgt);
      if (o_valid && rdy) begin
        accepts++;
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew || o_opc !== ew[6:0]) begin
          bad++; $display("FAIL random_stream: step=%0d pc=%h instr=%h want pc=%h instr=%h", i, o_pc, o_instr, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
      if (redir) exp_pc = tgt;
    end
    total++;
    if (accepts < 100) begin bad++; $display("FAIL random_progress: accepts=%0d want >=100", accepts); end
  endtask

  task automatic test_reset_midflight;
    int tries;
    tries = 0;
    do begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      tries++;
    end while (!o_fire && tries < 10);
    total++;
    if (!o_fire) begin bad++; $display("FAIL rst_setup: no grant within %0d cycles", tries); end
    // The response for that grant arrives while reset is held.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({if_valid, itcm_req, if_misalign} !== 3'b000 || itcm_addr !== 32'h0 ||
          if_pc !== 32'h0 || if_instr !== 32'h0 || if_opcode !== 7'h0) begin
        bad++;
        $display("FAIL rst_midflight: valid=%b req=%b addr=%h pc=%h instr=%h want reset values",
                 if_valid, itcm_req, itcm_addr, if_pc, if_instr);
      end
      @(posedge clk);
      #1;
    end
    // A stale rvalid is still high in the IDLE cycle after release.
    itcm_rvalid = 1'b1;
    itcm_rdata  = 32'hDEAD_BEEF;
    rst_n       = 1'b1;
    exp_pc      = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i < 3) begin
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_rvalid: valid=%b pc=%h at cycle %0d want 0", o_valid, o_pc, i); end
      end
      if (i == 3) begin
        total++;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL rst_restart: valid=%b at cycle 3 want 1", o_valid); end
      end
      if (o_valid) begin
        ew = itcm_word(exp_pc);
        total++;
        if (o_pc !== exp_pc || o_instr !== ew) begin
          bad++; $display("FAIL rst_stream: pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instr, exp_pc, ew);
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_gnt_toggle();
    test_wrap();
    test_misalign();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
